spi_ram_burst: RTL and testbench
================================

Name: spi_ram_burst

Overview:
- Parametrised command-decoded memory behind the SPI slave front end, replacing the fixed 8-bit/256-word RAM.
- Adds configurable data and address widths, plus address auto-increment on writes and reads.
- Adds multi-word burst reads with a ready/valid output handshake, so the SPI shifter can apply backpressure.
- Sits between the SPI receive deserialiser (din/rx_valid) and the transmit serialiser (dout/tx_valid/tx_ready).

Parameters:
- DATA_W, 8, memory word width; din is DATA_W+2 bits wide.
- ADDR_W, 8, address width; legal range 1 ≤ ADDR_W ≤ DATA_W.
- MEM_DEPTH, 256, number of words; must equal 2**ADDR_W.
- BURST_W, 4, burst-length field width; legal range 1 ≤ BURST_W ≤ DATA_W.
- AUTO_INC, 1, 1 = addresses post-increment after each write/read word; 0 = addresses fixed.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  DATA_W+2  command frame: din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload.
- rx_valid  input  1  din holds a valid frame this cycle.
- rx_ready  output  1  block accepts a frame this cycle.
- dout  output  DATA_W  read data word.
- tx_valid  output  1  dout valid, held until accepted.
- tx_ready  input  1  serialiser accepts dout this cycle.

Behaviour:
- Reset (rst_n=0 at posedge): wr_addr=0, rd_addr=0, remaining=0, state=IDLE, dout=0, tx_valid=0. Memory contents are not reset. Reset mid-burst aborts the burst immediately.
- Ports are driven as follows:
  - rx_ready = (state==IDLE), combinational.
  - A frame is accepted when rx_valid && rx_ready.
  - Frames presented while rx_ready=0 are ignored (no side effects).
- Opcodes, applied on accept:
  - 00 SET_WADDR: wr_addr <= payload[ADDR_W-1:0].
  - 01 WRITE: mem[wr_addr] <= payload; if AUTO_INC, wr_addr <= wr_addr+1.
  - 10 SET_RADDR: rd_addr <= payload[ADDR_W-1:0].
  - 11 READ: starts a burst of payload[BURST_W-1:0]+1 words (1..2**BURST_W).
    - remaining <= payload[BURST_W-1:0].
    - State goes to BURST.
    - Upper payload bits are ignored.
- FSM states are IDLE and BURST.
  - IDLE -> BURST on an accepted READ.
  - BURST -> IDLE on the handshake (tx_valid && tx_ready) of the word sent when remaining==0.
- Read timing:
  - A READ accepted at edge T gives dout = mem[rd_addr] and tx_valid=1 from T+1. If AUTO_INC, rd_addr increments at the same edge.
  - While tx_valid && !tx_ready, dout, tx_valid, rd_addr and remaining are all held stable.
  - On a handshake with remaining>0: next word presented at the next edge with no bubble; remaining decrements; rd_addr increments if AUTO_INC.
  - On a handshake with remaining==0: tx_valid=0 and dout=0 at the next edge; rx_ready=1 from that cycle.
- Address wrap: wr_addr and rd_addr wrap from MEM_DEPTH-1 to 0 (modulo 2**ADDR_W). Bursts may cross the wrap point.
- AUTO_INC=0: the write address never increments, and a burst returns the same word repeatedly.
- tx_valid is 0 in IDLE. dout is 0 whenever tx_valid=0.
- Minimum turnaround: a READ then a WRITE to the last-read address, with tx_ready tied high, takes 1+N cycles before the WRITE is accepted. The read data is always the pre-write value.
- Single-port behaviour: a write and a read never occur in the same cycle, because writes are only accepted in IDLE.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles with rx_valid=1 -> tx_valid=0, dout=0, rx_ready=1; no memory write occurs.
- Basic write/read, defaults:
  - Stimulus: SET_WADDR 0x10; WRITE 0xA5; WRITE 0x3C; SET_RADDR 0x10; READ len 0 (payload 0x00); tx_ready=1.
  - Response: one word dout=0xA5, tx_valid high exactly 1 cycle, 1 cycle after accept.
- Burst with backpressure:
  - Stimulus: write 0x01..0x04 at 0x20..0x23; SET_RADDR 0x20; READ payload 0x03; hold tx_ready=0 for 3 cycles, then toggle it.
  - Response: dout sequence 0x01,0x02,0x03,0x04; each word stable while stalled; rx_ready=0 throughout; frames sent during the burst are ignored (memory unchanged).
- Wrap-around:
  - Stimulus: SET_WADDR 0xFF; WRITE 0x11; WRITE 0x22; SET_RADDR 0xFF; READ payload 0x01.
  - Response: mem[0xFF]=0x11, mem[0x00]=0x22; burst returns 0x11 then 0x22.
- Reset mid-burst: during a 16-word burst, pulse rst_n=0 at word 5 -> tx_valid=0 next edge, state IDLE, addresses 0; a fresh READ from 0x00 returns the prior contents of mem[0x00].
- Parameter variant:
  - Stimulus: DATA_W=16, ADDR_W=4, AUTO_INC=0. SET_WADDR 0x0003; WRITE 0xBEEF; WRITE 0x1234; SET_RADDR 0x0003; READ payload 0x0002.
  - Response: dout = 0x1234 three times.

Source files
------------

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM behind the SPI slave: writes and address set-up in IDLE,
// multi-word burst reads streamed out through a ready/valid handshake.
module spi_ram_burst #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned BURST_W   = 4,
  parameter int unsigned AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [BURST_W-1:0] r_remaining;
  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];
  logic [DATA_W-1:0]  r_dout;
  logic               r_tx_valid;

  op_t                w_op;
  logic [DATA_W-1:0]  w_payload;
  logic               w_accept;
  logic               w_handshake;
  logic               w_last;
  logic [ADDR_W-1:0]  w_addr_step;

  assign w_op        = op_t'(din[DATA_W+1:DATA_W]);
  assign w_payload   = din[DATA_W-1:0];
  assign w_accept    = rx_valid && rx_ready;
  assign w_handshake = r_tx_valid && tx_ready;
  assign w_last      = w_handshake && (r_remaining == '0);
  assign w_addr_step = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && (w_op == OP_READ)) w_next_state = ST_BURST;
      ST_BURST: if (w_last) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (r_state == ST_IDLE);
  end

  // Memory is not reset, but frames seen while in reset must not write it.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && (w_op == OP_WRITE)) r_mem[r_wr_addr] <= w_payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_dout      <= '0;
      r_tx_valid  <= 1'b0;
    end else if (w_accept) begin
      case (w_op)
        OP_SET_WADDR: r_wr_addr <= w_payload[ADDR_W-1:0];
        OP_WRITE:     r_wr_addr <= r_wr_addr + w_addr_step;
        OP_SET_RADDR: r_rd_addr <= w_payload[ADDR_W-1:0];
        OP_READ: begin
          r_remaining <= w_payload[BURST_W-1:0];
          r_dout      <= r_mem[r_rd_addr];
          r_tx_valid  <= 1'b1;
          r_rd_addr   <= r_rd_addr + w_addr_step;
        end
        default: ;
      endcase
    end else if (w_handshake) begin
      if (r_remaining != '0) begin
        r_dout      <= r_mem[r_rd_addr];
        r_remaining <= r_remaining - BURST_W'(1);
        r_rd_addr   <= r_rd_addr + w_addr_step;
      end else begin
        r_dout     <= '0;
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: default 8-bit instance plus a 16-bit,
// 4-bit-address, fixed-address instance.
module tb_spi_ram_burst;

  logic        clk;
  logic        rst_n;
  logic [9:0]  din;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  dout;
  logic        tx_valid;
  logic        tx_ready;

  logic [17:0] din16;
  logic        rx_valid16;
  logic        rx_ready16;
  logic [15:0] dout16;
  logic        tx_valid16;
  logic        tx_ready16;

  int n_checks = 0;
  int n_pass   = 0;

  spi_ram_burst u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  spi_ram_burst #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .MEM_DEPTH (16),
    .BURST_W   (4),
    .AUTO_INC  (0)
  ) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din16),
    .rx_valid (rx_valid16),
    .rx_ready (rx_ready16),
    .dout     (dout16),
    .tx_valid (tx_valid16),
    .tx_ready (tx_ready16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left at a negedge; the frame is accepted at the posedge between.
  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    din      = {op, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send16(input logic [1:0] op, input logic [15:0] pl);
    din16      = {op, pl};
    rx_valid16 = 1'b1;
    @(negedge clk);
    rx_valid16 = 1'b0;
  endtask

  task automatic test_reset;
    send(2'b00, 8'h00);
    send(2'b01, 8'h5A);
    rst_n    = 1'b0;
    din      = {2'b01, 8'hEE};
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else n_pass++;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else n_pass++;
    n_checks++;
    if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b want 1", rx_ready); else n_pass++;
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    send(2'b11, 8'h00);
    n_checks++;
    if (dout !== 8'h5A) $display("FAIL reset_no_write got %h want 5a", dout); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send(2'b00, 8'h10);
    send(2'b01, 8'hA5);
    send(2'b01, 8'h3C);
    send(2'b10, 8'h10);
    tx_ready = 1'b1;
    send(2'b11, 8'h00);
    n_checks++;
    if (tx_valid !== 1'b1 || dout !== 8'hA5)
      $display("FAIL basic_word got v=%b d=%h want v=1 d=a5", tx_valid, dout); else n_pass++;
    n_checks++;
    if (rx_ready !== 1'b0) $display("FAIL basic_busy got %b want 0", rx_ready); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || dout !== 8'h00 || rx_ready !== 1'b1)
      $display("FAIL basic_end got v=%b d=%h r=%b want v=0 d=00 r=1", tx_valid, dout, rx_ready);
    else n_pass++;
    send(2'b10, 8'h11);
    send(2'b11, 8'h00);
    n_checks++;
    if (dout !== 8'h3C) $display("FAIL basic_second got %h want 3c", dout); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_burst_bp;
    int idx;
    int cyc;
    send(2'b00, 8'h20);
    for (int i = 0; i < 4; i++) send(2'b01, 8'(i + 1));
    send(2'b10, 8'h20);
    tx_ready = 1'b0;
    send(2'b11, 8'h03);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      n_checks++;
      if (tx_valid !== 1'b1 || dout !== 8'(idx + 1) || rx_ready !== 1'b0)
        $display("FAIL bp_word%0d got v=%b d=%h r=%b want v=1 d=%h r=0",
                 idx, tx_valid, dout, rx_ready, 8'(idx + 1));
      else n_pass++;
      // Stalled cycles carry frames that must be ignored.
      tx_ready = (cyc >= 3) && cyc[0];
      rx_valid = !tx_ready;
      din      = cyc[1] ? {2'b00, 8'h20} : {2'b01, 8'hFF};
      if (tx_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    n_checks++;
    if (idx != 4 || tx_valid !== 1'b0 || rx_ready !== 1'b1)
      $display("FAIL bp_end got idx=%0d v=%b r=%b want idx=4 v=0 r=1", idx, tx_valid, rx_ready);
    else n_pass++;
    tx_ready = 1'b1;
    send(2'b10, 8'h20);
    send(2'b11, 8'h03);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout !== 8'(i + 1)) $display("FAIL bp_mem%0d got %h want %h", i, dout, 8'(i + 1));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    tx_ready = 1'b1;
    send(2'b11, 8'h01);
    n_checks++;
    if (dout !== 8'h11) $display("FAIL wrap_w0 got %h want 11", dout); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dout !== 8'h22 || tx_valid !== 1'b1)
      $display("FAIL wrap_w1 got d=%h v=%b want d=22 v=1", dout, tx_valid); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL wrap_end got %b want 0", tx_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_burst;
    send(2'b00, 8'h30);
    for (int i = 0; i < 16; i++) send(2'b01, 8'(8'h40 + i));
    send(2'b10, 8'h30);
    tx_ready = 1'b1;
    send(2'b11, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (dout !== 8'(8'h40 + i)) $display("FAIL mid_word%0d got %h want %h", i, dout, 8'(8'h40 + i));
      else n_pass++;
      if (i == 4) rst_n = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (tx_valid !== 1'b0 || dout !== 8'h00 || rx_ready !== 1'b1)
      $display("FAIL mid_reset got v=%b d=%h r=%b want v=0 d=00 r=1", tx_valid, dout, rx_ready);
    else n_pass++;
    send(2'b11, 8'h00);
    n_checks++;
    if (dout !== 8'h22) $display("FAIL mid_raddr0 got %h want 22", dout); else n_pass++;
    @(negedge clk);
    send(2'b01, 8'h77);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    n_checks++;
    if (dout !== 8'h77) $display("FAIL mid_waddr0 got %h want 77", dout); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_param_variant;
    tx_ready16 = 1'b1;
    send16(2'b00, 16'h0003);
    send16(2'b01, 16'hBEEF);
    send16(2'b01, 16'h1234);
    send16(2'b10, 16'h0003);
    send16(2'b11, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_valid16 !== 1'b1 || dout16 !== 16'h1234)
        $display("FAIL var_word%0d got v=%b d=%h want v=1 d=1234", i, tx_valid16, dout16);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (tx_valid16 !== 1'b0 || dout16 !== 16'h0000 || rx_ready16 !== 1'b1)
      $display("FAIL var_end got v=%b d=%h r=%b want v=0 d=0000 r=1", tx_valid16, dout16, rx_ready16);
    else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    din16      = '0;
    rx_valid16 = 1'b0;
    tx_ready16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_burst_bp;
    test_wrap;
    test_reset_mid_burst;
    test_param_variant;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
